// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache types, geometry constants and line-address helpers
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_RF,
    S_TAG,
    S_DONE
  } seq_state_t;

  localparam int WORD_BYTES = 4;

  // Geometry of the unified cache arrays
  localparam int CACHE_LINES          = 64;
  localparam int CACHE_WORDS_PER_LINE = 4;
  localparam int CACHE_LINE_BYTES     = CACHE_WORDS_PER_LINE * WORD_BYTES;
  localparam int CACHE_INDEX_W        = $clog2(CACHE_LINES);

  // Mask that clears the byte offset within a line; callers take the low ADDR_W bits.
  function automatic logic [63:0] line_base_mask(input int words_per_line);
    logic [63:0] span;
    span = 64'(WORD_BYTES * words_per_line);
    return ~(span - 64'd1);
  endfunction

endpackage

// File: rtl/line_word_counter.sv
// rtl/line_word_counter.sv - word index within a cache line, advanced once per memory handshake
module line_word_counter #(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              inc,
  output logic [$clog2(WORDS_PER_LINE)-1:0] cnt,
  output logic                              last
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + IDX_W'(1);
    end
  end

  assign last = (cnt == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_line_sequencer.sv
// rtl/cache_line_sequencer.sv - victim write-back then line refill for a cache miss
module cache_line_sequencer
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              dirty,
  input  logic [ADDR_W-1:0]                 victim_addr,
  input  logic [ADDR_W-1:0]                 miss_addr,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(WORDS_PER_LINE)-1:0] cache_ridx,
  input  logic [31:0]                       cache_rdata,
  output logic                              cache_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0] cache_widx,
  output logic [31:0]                       cache_wdata,
  output logic                              tag_we,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [31:0]                       mem_wdata,
  input  logic                              mem_ack,
  input  logic [31:0]                       mem_rdata
);

  localparam int                IDX_W     = $clog2(WORDS_PER_LINE);
  localparam logic [63:0]       MASK64    = line_base_mask(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] LINE_MASK = MASK64[ADDR_W-1:0];

  seq_state_t        state;
  seq_state_t        state_next;
  logic [ADDR_W-1:0] victim_base;
  logic [ADDR_W-1:0] miss_base;
  logic [ADDR_W-1:0] word_off;
  logic [IDX_W-1:0]  cnt;
  logic              last;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              accept;

  line_word_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .last(last)
  );

  // Offset stays inside the line, so base + offset never carries past the line.
  assign word_off = ADDR_W'({cnt, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      victim_base <= '0;
      miss_base   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      if (accept) begin
        victim_base <= victim_addr & LINE_MASK;
        miss_base   <= miss_addr & LINE_MASK;
      end
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cache_ridx  = '0;
    cache_we    = 1'b0;
    cache_widx  = '0;
    cache_wdata = '0;
    tag_we      = 1'b0;
    done        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = dirty ? S_WB : S_RF;
        end
      end
      S_WB: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = victim_base + word_off;
        cache_ridx = cnt;
        mem_wdata  = cache_rdata;
        if (mem_ack) begin
          if (last) begin
            cnt_clr    = 1'b1;
            state_next = S_RF;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_RF: begin
        mem_req  = 1'b1;
        mem_addr = miss_base + word_off;
        if (mem_ack) begin
          cache_we    = 1'b1;
          cache_widx  = cnt;
          cache_wdata = mem_rdata;
          cnt_inc     = 1'b1;
          if (last) begin
            state_next = S_TAG;
          end
        end
      end
      S_TAG: begin
        tag_we     = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_sequencer.sv
// tb/tb_cache_line_sequencer.sv - scoreboard bench for cache_line_sequencer with a randomized memory model
module tb_cache_line_sequencer;

  localparam int W  = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, dirty;
  logic [AW-1:0] victim_addr, miss_addr;
  logic          busy, done, cache_we, tag_we, mem_req, mem_we, mem_ack;
  logic [1:0]    cache_ridx, cache_widx;
  logic [31:0]   cache_rdata, cache_wdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   victim_line [W];

  assign cache_rdata = victim_line[cache_ridx];

  cache_line_sequencer #(.WORDS_PER_LINE(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .dirty(dirty),
    .victim_addr(victim_addr), .miss_addr(miss_addr),
    .busy(busy), .done(done),
    .cache_ridx(cache_ridx), .cache_rdata(cache_rdata),
    .cache_we(cache_we), .cache_widx(cache_widx), .cache_wdata(cache_wdata),
    .tag_we(tag_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Eight-word instance with memory acknowledging every cycle
  logic          start8, dirty8, busy8, done8, cache_we8, tag_we8, mem_req8, mem_we8;
  logic [AW-1:0] victim_addr8, miss_addr8, mem_addr8;
  logic [2:0]    cache_ridx8, cache_widx8;
  logic [31:0]   cache_wdata8, mem_wdata8;
  logic          mem_ack8;
  logic [31:0]   cache_rdata8, mem_rdata8;

  assign mem_ack8     = 1'b1;
  assign cache_rdata8 = 32'h0;
  assign mem_rdata8   = 32'h5a5a_0000;

  cache_line_sequencer #(.WORDS_PER_LINE(8), .ADDR_W(AW)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dirty(dirty8),
    .victim_addr(victim_addr8), .miss_addr(miss_addr8),
    .busy(busy8), .done(done8),
    .cache_ridx(cache_ridx8), .cache_rdata(cache_rdata8),
    .cache_we(cache_we8), .cache_widx(cache_widx8), .cache_wdata(cache_wdata8),
    .tag_we(tag_we8), .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .mem_ack(mem_ack8), .mem_rdata(mem_rdata8)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          idx;
  } mem_txn_t;

  mem_txn_t exp_q[$];
  int       wait_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int win_lo      = 1;
  int win_hi      = 0;
  int exp_done_cyc = -1;
  int exp_tag_cyc  = -1;
  int done_count   = 0;
  bit noise_en     = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: per-word wait counts come from wait_q; ack is noise while no request is open.
  initial begin
    int cur_wait;
    cur_wait  = -1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (rst) begin
        mem_ack  = 1'b0;
        cur_wait = -1;
      end else if (mem_req) begin
        if (cur_wait < 0) begin
          cur_wait = 0;
          if (wait_q.size() > 0) cur_wait = wait_q.pop_front();
        end
        if (cur_wait > 0) begin
          mem_ack = 1'b0;
          cur_wait--;
        end else begin
          mem_ack  = 1'b1;
          cur_wait = -1;
        end
      end else begin
        mem_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks per-cycle timing.
  initial begin
    mem_txn_t      t;
    bit            prev_stall;
    logic          prev_we;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wdata;
    bit            in_win;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        in_win = (cyc >= win_lo) && (cyc <= win_hi);
        if (prev_stall) begin
          chk("hold_req", mem_req, 1);
          chk("hold_we", mem_we, prev_we);
          chk("hold_addr", mem_addr, prev_addr);
          chk("hold_wdata", mem_wdata, prev_wdata);
        end
        if (mem_req && mem_ack) begin
          chk("mem_txn_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("mem_we", mem_we, t.we);
            chk("mem_addr", mem_addr, t.addr);
            if (t.we) begin
              chk("mem_wdata", mem_wdata, t.wdata);
              chk("cache_we_in_wb", cache_we, 0);
            end else begin
              chk("cache_we", cache_we, 1);
              chk("cache_widx", cache_widx, t.idx);
              chk("cache_wdata", cache_wdata, mem_rdata);
            end
          end
        end else begin
          chk("cache_we_no_ack", cache_we, 0);
        end
        chk("tag_we", tag_we, cyc == exp_tag_cyc);
        chk("done", done, cyc == exp_done_cyc);
        chk("busy", busy, in_win);
        if (!in_win) begin
          chk("idle_req", mem_req, 0);
          chk("idle_addr", mem_addr, 0);
        end
        if (done) done_count++;
        prev_stall = mem_req && !mem_ack;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
      end
    end
  end

  task automatic run_txn(input bit d, input logic [31:0] va, input logic [31:0] ma,
                         input bit tied, input bit extra);
    logic [31:0] mask, vb, mb;
    int          waits, w, len, s, done_before;
    mask  = ~(32'(4 * W) - 32'd1);
    vb    = va & mask;
    mb    = ma & mask;
    waits = 0;
    for (int k = 0; k < W; k++) victim_line[k] = $urandom;
    if (d) begin
      for (int k = 0; k < W; k++) begin
        w = tied ? 0 : int'($urandom_range(0, 3));
        waits += w;
        wait_q.push_back(w);
        exp_q.push_back('{we: 1'b1, addr: vb + 32'(4 * k), wdata: victim_line[k], idx: k});
      end
    end
    for (int k = 0; k < W; k++) begin
      w = tied ? 0 : int'($urandom_range(0, 3));
      waits += w;
      wait_q.push_back(w);
      exp_q.push_back('{we: 1'b0, addr: mb + 32'(4 * k), wdata: 32'h0, idx: k});
    end
    len         = (d ? 2 * W : W) + 2 + waits;
    done_before = done_count;
    @(negedge clk);
    start        = 1'b1;
    dirty        = d;
    victim_addr  = va;
    miss_addr    = ma;
    s            = cyc + 1;
    win_lo       = s;
    win_hi       = s + len - 1;
    exp_done_cyc = win_hi;
    exp_tag_cyc  = win_hi - 1;
    for (int r = 1; r <= len + 3; r++) begin
      @(negedge clk);
      start = extra && (r == 2 || r == len);
      dirty = 1'b1;
      victim_addr = $urandom;
      miss_addr   = $urandom;
    end
    start = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("one_done", done_count - done_before, 1);
  endtask

  task automatic reset_mid_wb();
    logic [31:0] vb;
    int          s;
    vb = 32'h0000_3010 & ~(32'(4 * W) - 32'd1);
    for (int k = 0; k < W; k++) victim_line[k] = $urandom;
    for (int k = 0; k < 2; k++) begin
      wait_q.push_back(0);
      exp_q.push_back('{we: 1'b1, addr: vb + 32'(4 * k), wdata: victim_line[k], idx: k});
    end
    @(negedge clk);
    start        = 1'b1;
    dirty        = 1'b1;
    victim_addr  = 32'h0000_3010;
    miss_addr    = 32'h0000_7000;
    s            = cyc + 1;
    win_lo       = s;
    win_hi       = s + 2;
    exp_done_cyc = -1;
    exp_tag_cyc  = -1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_q.delete();
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tag", tag_we, 0);
    chk("rst_mid_two_acks", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run8();
    int n, got_done;
    n        = 0;
    got_done = -1;
    @(negedge clk);
    start8      = 1'b1;
    dirty8      = 1'b0;
    miss_addr8  = 32'hFFFF_FFE4;
    victim_addr8 = 32'h0;
    @(negedge clk);
    start8 = 1'b0;
    for (int r = 1; r <= 14; r++) begin
      if (mem_req8 && mem_ack8) begin
        chk("w8_addr", mem_addr8, 32'hFFFF_FFE0 + 32'(4 * n));
        chk("w8_we", mem_we8, 0);
        chk("w8_widx", cache_widx8, n);
        n++;
      end
      if (done8) got_done = r;
      @(negedge clk);
    end
    chk("w8_reads", n, 8);
    chk("w8_done_cycle", got_done, 10);
    chk("w8_idle_req", mem_req8, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    dirty        = 1'b0;
    victim_addr  = '0;
    miss_addr    = '0;
    start8       = 1'b0;
    dirty8       = 1'b0;
    victim_addr8 = '0;
    miss_addr8   = '0;
    for (int k = 0; k < W; k++) victim_line[k] = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_req", mem_req, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_tag_we", tag_we, 0);
    chk("reset_cache_we", cache_we, 0);
    rst = 1'b0;

    run_txn(1'b0, 32'h0, 32'h0000_1234, 1'b1, 1'b0);
    run_txn(1'b1, 32'h0000_8008, 32'h0000_0040, 1'b1, 1'b0);
    run_txn(1'b0, 32'h0000_2000, 32'h0000_5558, 1'b1, 1'b1);
    reset_mid_wb();
    run_txn(1'b1, 32'h0000_8008, 32'h0000_0040, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 1'b0);
    end
    run8();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
